coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end stage that sits directly upstream of the soda vending FSM. It synchronises and debounces the raw "next" push-button, then issues one clean single-cycle `next` pulse per physical press. It captures the coin-selector switches into a stable `coin_in` code that the vending FSM samples. When the vending FSM is not accepting coins, the block diverts the inserted coin to a reject path and keeps a running count of accepted coin value.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a level must hold to count as stable; legal range is ≥2. The board build overrides it, e.g. 500000.
- `TOTAL_W`, 8: width of the accepted-value accumulator.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `btn_next`  in  1  raw push-button, asynchronous to `clk`, bouncy
- `coin_sel`  in  2  raw coin switches: 00 none, 01 value-1, 10 value-2, 11 value-5
- `accept_en`  in  1  driven by the vending FSM's `check_coin_in`; high means coins are accepted
- `next`  out  1  one-cycle pulse per debounced press
- `coin_in`  out  2  held coin code for the vending FSM
- `reject`  out  1  one-cycle pulse when a non-zero coin is pressed while `accept_en` is low
- `reject_code`  out  2  coin code that was rejected, held until the next reject
- `total`  out  TOTAL_W  sum of accepted coin values, wraps modulo 2^TOTAL_W
- `busy`  out  1  high in any state other than IDLE

## Operation
- `btn_next` passes through a 2-flop synchroniser to give `btn_s`. `coin_sel` passes through a 2-flop synchroniser to give `sel_s`.
- FSM states are IDLE, BOUNCE_PRESS, PRESSED and BOUNCE_RELEASE.
- **IDLE:**
  - `btn_s`=1 → go to BOUNCE_PRESS and clear `cnt`.
- **BOUNCE_PRESS:**
  - `btn_s`=0 → return to IDLE; no pulse is issued.
  - `btn_s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → go to PRESSED and perform the press action on that same edge.
  - Otherwise `cnt` increments.
- **Press action** (all registered on one edge):
  - `next`<=1.
  - If `accept_en`: `coin_in`<=`sel_s`, and `total` += value(`sel_s`). Values are 0, 1, 2 and 5.
  - Else: `coin_in`<=00. If `sel_s`≠00, also `reject`<=1 and `reject_code`<=`sel_s`.
- **PRESSED:**
  - `btn_s`=0 → go to BOUNCE_RELEASE and clear `cnt`.
- **BOUNCE_RELEASE:**
  - `btn_s`=1 → return to PRESSED.
  - `btn_s`=0 and `cnt`==DEBOUNCE_CYCLES-1 → go to IDLE.
  - Otherwise `cnt` increments.
- `next` and `reject` are high for exactly one cycle.
- `coin_in` holds its value until the next press action. This keeps it stable through the vending FSM's 2-flop edge detector.
- A held button produces exactly one pulse. A new pulse requires a debounced release followed by a debounced press.
- `accept_en` and `sel_s` are sampled only on the press-action edge. Later changes do not alter `coin_in` or `total`.
- `total` addition is modulo 2^TOTAL_W: 255 + 5 → 4 for TOTAL_W=8.
- Illegal state encodings → IDLE.

## Timing
- Reset is asynchronous:
  - State = IDLE, `cnt`=0, synchroniser flops = 0.
  - Outputs: `next`=0, `coin_in`=00, `reject`=0, `reject_code`=00, `total`=0, `busy`=0.
- Reset asserted mid-debounce or mid-press cancels any pending pulse. After deassertion a button still held high needs a full synchroniser plus debounce sequence before it pulses.
- Press latency: let edge 0 be the first edge that samples `btn_next`=1.
  - `btn_s`=1 after edge 1.
  - BOUNCE_PRESS after edge 2.
  - `next`, `coin_in`, `reject` and `total` update on edge DEBOUNCE_CYCLES+2, i.e. edge 6 for the default.
- Release latency: IDLE is reached on edge DEBOUNCE_CYCLES+2 after the first edge that samples `btn_next`=0.
- Minimum press-to-press period is 2·(DEBOUNCE_CYCLES+2) cycles.
- A glitch on `btn_s` shorter than DEBOUNCE_CYCLES produces no pulse.

## Structure
- Shared package `vend_pkg` holds:
  - coin code constants COIN_NONE, COIN_1, COIN_2, COIN_5;
  - the coin value function;
  - the acceptor state enum.
  
  The vending FSM reuses the coin constants.
- Sub-module `sync2`: parameterised-width 2-flop synchroniser with asynchronous reset. It is instantiated once for `btn_next` and once for `coin_sel`.

## Test plan
- **Clean press:** reset, `accept_en`=1, `coin_sel`=10, `btn_next` held high for 20 cycles → exactly one `next` pulse on edge 6, `coin_in`=10, `total`=2, `reject`=0.
- **Bounce:** toggle `btn_next` 1-0-1-0 with 2-cycle periods, then hold high → exactly one pulse, occurring 6 edges after the final rise.
- **Reject:** `accept_en`=0, `coin_sel`=11, press → `next` pulse, `coin_in`=00, `reject` pulse, `reject_code`=11, `total` unchanged.
- **Wrap and hold:** preload `total` to 254 via 50×5 + 2×2 presses (254 = 250 + 4), then one value-5 press → `total`=3. Change `coin_sel` while the button is held → `coin_in` is unchanged.
- **Reset mid-debounce:** assert `reset` on edge 4 of a press, release it, keep `btn_next` high → no pulse before edge 6 counted from the reset release, then one pulse. All outputs are 0 during reset.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end: coin codes, coin value
// decode and the coin acceptor state encoding.
package vend_pkg;

  localparam int unsigned COIN_W  = 2;
  localparam int unsigned VALUE_W = 3;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_1    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_2    = 2'b10;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_BOUNCE_PRESS   = 2'd1,
    ST_PRESSED        = 2'd2,
    ST_BOUNCE_RELEASE = 2'd3
  } acc_state_e;

  // Monetary value of a coin code.
  function automatic logic [VALUE_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [VALUE_W-1:0] v;
    case (code)
      COIN_1:  v = 3'd1;
      COIN_2:  v = 3'd2;
      COIN_5:  v = 3'd5;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, W bits wide.
// Ports: clk, reset (async active-high), d (raw input), q (synchronised).
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the next button into a single pulse per
// press, latches the coin selection at that moment, and either credits the
// coin to a running total or diverts it to the reject path.
// Ports: clk, reset (async active-high), btn_next (raw button), coin_sel (raw
// switches), accept_en (from vending FSM); outputs next, coin_in, reject,
// reject_code, total, busy.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TOTAL_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_next,
  input  logic [1:0]         coin_sel,
  input  logic               accept_en,
  output logic               next,
  output logic [1:0]         coin_in,
  output logic               reject,
  output logic [1:0]         reject_code,
  output logic [TOTAL_W-1:0] total,
  output logic               busy
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic [1:0]       sel_s;
  acc_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press;
  logic             next_n, reject_n, busy_n;
  logic [1:0]       coin_in_n, reject_code_n;
  logic [TOTAL_W-1:0] total_n;

  sync2 #(.W(1)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_next),
    .q     (btn_s)
  );

  sync2 #(.W(2)) u_sync_sel (
    .clk   (clk),
    .reset (reset),
    .d     (coin_sel),
    .q     (sel_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      next        <= 1'b0;
      coin_in     <= COIN_NONE;
      reject      <= 1'b0;
      reject_code <= COIN_NONE;
      total       <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      next        <= next_n;
      coin_in     <= coin_in_n;
      reject      <= reject_n;
      reject_code <= reject_code_n;
      total       <= total_n;
      busy        <= busy_n;
    end
  end

  // Debounce FSM; the press action fires on the edge entering PRESSED.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    press         = 1'b0;
    next_n        = 1'b0;
    reject_n      = 1'b0;
    coin_in_n     = coin_in;
    reject_code_n = reject_code;
    total_n       = total;

    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_n = ST_BOUNCE_PRESS;
          cnt_n   = '0;
        end
      end
      ST_BOUNCE_PRESS: begin
        if (!btn_s) begin
          state_n = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_PRESSED;
          press   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_n = ST_BOUNCE_RELEASE;
          cnt_n   = '0;
        end
      end
      ST_BOUNCE_RELEASE: begin
        if (btn_s) begin
          state_n = ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Coin handling sampled only on the press edge.
    if (press) begin
      next_n = 1'b1;
      if (accept_en) begin
        coin_in_n = sel_s;
        total_n   = total + TOTAL_W'(coin_value(sel_s));
      end else begin
        coin_in_n = COIN_NONE;
        if (sel_s != COIN_NONE) begin
          reject_n      = 1'b1;
          reject_code_n = sel_s;
        end
      end
    end

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next;
  logic [1:0] coin_sel;
  logic       accept_en;
  logic       next;
  logic [1:0] coin_in;
  logic       reject;
  logic [1:0] reject_code;
  logic [7:0] total;
  logic       busy;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .TOTAL_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_next),
    .coin_sel    (coin_sel),
    .accept_en   (accept_en),
    .next        (next),
    .coin_in     (coin_in),
    .reject      (reject),
    .reject_code (reject_code),
    .total       (total),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] coin_in;
    logic       reject;
    logic [1:0] reject_code;
    logic [7:0] total;
  } exp_t;

  typedef struct {
    logic       accept;
    logic [1:0] sel;
    int         hold;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_next_cyc = -1;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every next pulse pops one expected record.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("stray_reject", int'(reject && !next), 0);
      if (next) begin
        pulses++;
        last_next_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_next", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("coin_in", int'(coin_in), int'(e.coin_in));
          chk("reject", int'(reject), int'(e.reject));
          chk("reject_code", int'(reject_code), int'(e.reject_code));
          chk("total", int'(total), int'(e.total));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_next = 1'b0;
    #1;
    chk("rst_next", int'(next), 0);
    chk("rst_coin_in", int'(coin_in), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_reject_code", int'(reject_code), 0);
    chk("rst_total", int'(total), 0);
    chk("rst_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One press: drive inputs, push expectation, hold, release and settle.
  task automatic press(input logic acc, input logic [1:0] sel, input int hold,
                       input exp_t e, input logic check_lat);
    int c;
    int p0;
    @(negedge clk);
    accept_en = acc;
    coin_sel  = sel;
    btn_next  = 1'b1;
    c  = cyc;
    p0 = pulses;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    chk("pulse_count", pulses - p0, 1);
    if (check_lat) chk("press_latency", last_next_cyc - c, 7);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after_release", int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    exp_t e;
    int c;
    int p0;

    // accept, sel, hold, {coin_in, reject, reject_code, total}
    vecs[0] = '{1'b1, 2'b10, 20, '{2'b10, 1'b0, 2'b00, 8'd2}};
    vecs[1] = '{1'b1, 2'b01, 9,  '{2'b01, 1'b0, 2'b00, 8'd3}};
    vecs[2] = '{1'b0, 2'b11, 9,  '{2'b00, 1'b1, 2'b11, 8'd3}};
    vecs[3] = '{1'b1, 2'b11, 12, '{2'b11, 1'b0, 2'b11, 8'd8}};
    vecs[4] = '{1'b0, 2'b00, 9,  '{2'b00, 1'b0, 2'b11, 8'd8}};
    vecs[5] = '{1'b1, 2'b00, 9,  '{2'b00, 1'b0, 2'b11, 8'd8}};
    vecs[6] = '{1'b0, 2'b10, 9,  '{2'b00, 1'b1, 2'b10, 8'd8}};

    reset = 1'b1;
    btn_next = 1'b0;
    coin_sel = 2'b00;
    accept_en = 1'b0;
    do_reset();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++)
      press(vecs[i].accept, vecs[i].sel, vecs[i].hold, vecs[i].exp, 1'b1);

    // Bounce: 1-0-1-0 with 2-cycle periods, then hold high.
    @(negedge clk);
    accept_en = 1'b1;
    coin_sel  = 2'b01;
    p0 = pulses;
    for (int k = 0; k < 2; k++) begin
      btn_next = 1'b1;
      repeat (2) @(negedge clk);
      btn_next = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_pulse", pulses - p0, 0);
    press(1'b1, 2'b01, 15, '{2'b01, 1'b0, 2'b10, 8'd9}, 1'b1);

    // Wrap: preload 254 from zero, then a value-5 press wraps to 3.
    do_reset();
    for (int i = 0; i < 52; i++) begin
      if (i < 50) e = '{2'b11, 1'b0, 2'b00, 8'(5 * (i + 1))};
      else        e = '{2'b10, 1'b0, 2'b00, 8'(250 + 2 * (i - 49))};
      press(1'b1, (i < 50) ? 2'b11 : 2'b10, 8, e, 1'b0);
    end
    chk("preload_total", int'(total), 254);

    // Hold: change coin_sel and accept_en after the pulse, coin_in must not move.
    @(negedge clk);
    accept_en = 1'b1;
    coin_sel  = 2'b11;
    btn_next  = 1'b1;
    c = cyc;
    sb.push_back('{2'b11, 1'b0, 2'b00, 8'd3});
    repeat (9) @(negedge clk);
    chk("wrap_latency", last_next_cyc - c, 7);
    coin_sel  = 2'b01;
    accept_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_coin_in", int'(coin_in), 3);
    chk("hold_total", int'(total), 3);
    chk("hold_busy", int'(busy), 1);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-debounce: reset after edge 4 of a press, button kept high.
    accept_en = 1'b1;
    coin_sel  = 2'b10;
    @(negedge clk);
    btn_next = 1'b1;
    c = cyc;
    p0 = pulses;
    wait (cyc == c + 5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_next", int'(next), 0);
    chk("midrst_total", int'(total), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_coin_in", int'(coin_in), 0);
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    sb.push_back('{2'b10, 1'b0, 2'b00, 8'd2});
    repeat (12) @(negedge clk);
    chk("midrst_pulse_count", pulses - p0, 1);
    chk("midrst_latency", last_next_cyc - c, 7);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
